// File: rtl/huff_mcu_scheduler.sv
// Sequences the Y, Cb and Cr Huffman encoders for one MCU and merges their
// bitstream words into a single registered, component-tagged stream.
module huff_mcu_scheduler #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ready,
  output logic [2:0]  enc_enable,
  input  logic [2:0]  enc_data_ready,
  input  logic [95:0] enc_bitstream,
  input  logic [2:0]  enc_eob,
  input  logic [14:0] enc_reg_count,
  output logic        out_valid,
  output logic [31:0] out_word,
  output logic [1:0]  out_comp,
  output logic        mcu_done,
  output logic [4:0]  residual_cnt,
  output logic        err_stray,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_EN_Y, S_WAIT_Y, S_EN_CB, S_WAIT_CB, S_EN_CR, S_WAIT_CR, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_reg, state_next, adv_state;
  logic [CNT_W-1:0] wd_reg, wd_next;
  logic             eob_hit_reg, eob_hit_next;
  logic             in_wait, act_dr, act_eob, stray, timeout, accept;
  logic [1:0]       act;
  logic [2:0]       act_mask;
  logic [31:0]      act_word;
  logic             unused_reg_count;

  assign unused_reg_count = ^enc_reg_count[9:0];

  always_comb begin
    in_wait   = 1'b0;
    act       = 2'd0;
    act_mask  = 3'b000;
    adv_state = S_IDLE;
    case (state_reg)
      S_WAIT_Y:  begin in_wait = 1'b1; act = 2'd0; act_mask = 3'b001; adv_state = S_EN_CB; end
      S_WAIT_CB: begin in_wait = 1'b1; act = 2'd1; act_mask = 3'b010; adv_state = S_EN_CR; end
      S_WAIT_CR: begin in_wait = 1'b1; act = 2'd2; act_mask = 3'b100; adv_state = S_DONE;  end
      default:   ;
    endcase
  end

  always_comb begin
    act_word = enc_bitstream[31:0];
    case (act)
      2'd1:    act_word = enc_bitstream[63:32];
      2'd2:    act_word = enc_bitstream[95:64];
      default: act_word = enc_bitstream[31:0];
    endcase
  end

  assign act_dr  = |(enc_data_ready & act_mask);
  assign act_eob = |(enc_eob & act_mask);
  // Anything not coming from the encoder we are waiting on is dropped.
  assign stray   = |(enc_data_ready & ~act_mask);
  assign timeout = in_wait && !eob_hit_reg && !act_eob && (wd_reg == WD_LAST);
  assign accept  = (state_reg == S_IDLE) && start;

  // eob is captured into eob_hit_reg and acted on one cycle later.
  always_comb begin
    state_next   = state_reg;
    wd_next      = wd_reg;
    eob_hit_next = 1'b0;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_EN_Y;
      S_EN_Y:  begin state_next = S_WAIT_Y;  wd_next = '0; end
      S_EN_CB: begin state_next = S_WAIT_CB; wd_next = '0; end
      S_EN_CR: begin state_next = S_WAIT_CR; wd_next = '0; end
      S_WAIT_Y, S_WAIT_CB, S_WAIT_CR: begin
        if (eob_hit_reg) begin
          state_next = adv_state;
        end else if (timeout) begin
          state_next = S_IDLE;
        end else begin
          wd_next      = wd_reg + 1'b1;
          eob_hit_next = act_eob;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      wd_reg       <= '0;
      eob_hit_reg  <= 1'b0;
      ready        <= 1'b1;
      enc_enable   <= 3'b000;
      out_valid    <= 1'b0;
      out_word     <= 32'd0;
      out_comp     <= 2'd0;
      mcu_done     <= 1'b0;
      residual_cnt <= 5'd0;
      err_stray    <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wd_reg      <= wd_next;
      eob_hit_reg <= eob_hit_next;
      ready       <= (state_next == S_IDLE);
      enc_enable  <= {state_next == S_EN_CR, state_next == S_EN_CB, state_next == S_EN_Y};
      mcu_done    <= (state_next == S_DONE);
      out_valid   <= act_dr;
      if (act_dr) begin
        out_word <= act_word;
        out_comp <= act;
      end
      if (accept) begin
        err_stray    <= 1'b0;
        err_timeout  <= 1'b0;
        residual_cnt <= 5'd0;
      end
      if (stray)
        err_stray <= 1'b1;
      if (timeout)
        err_timeout <= 1'b1;
      if (state_reg == S_WAIT_CR && !eob_hit_reg && enc_eob[2])
        residual_cnt <= enc_reg_count[14:10];
    end
  end

endmodule

// File: tb/tb_huff_mcu_scheduler.sv
// Randomized and directed bench for huff_mcu_scheduler against a behavioural
// per-component sequencing model.
module tb_huff_mcu_scheduler;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  dr, eob;
  logic [95:0] bs;
  logic [14:0] rc;
  logic        ready, out_valid, mcu_done, err_stray, err_timeout;
  logic [2:0]  enc_enable;
  logic [31:0] out_word;
  logic [1:0]  out_comp;
  logic [4:0]  residual_cnt;

  always #5 clk = ~clk;

  huff_mcu_scheduler #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .enc_enable(enc_enable),
    .enc_data_ready(dr), .enc_bitstream(bs), .enc_eob(eob), .enc_reg_count(rc),
    .out_valid(out_valid), .out_word(out_word), .out_comp(out_comp),
    .mcu_done(mcu_done), .residual_cnt(residual_cnt),
    .err_stray(err_stray), .err_timeout(err_timeout)
  );

  int errors = 0, checks = 0, cyc = 0;

  // Model: phase 0 idle, 1 enable pulse, 2 waiting on encoder c, 3 done.
  int ph = 0, c = 0, elapsed = 0, accepts = 0;
  bit seen = 0;
  bit e_ready, e_valid, e_done, e_stray, e_to;
  logic [2:0]  e_en;
  logic [31:0] e_word;
  logic [1:0]  e_comp;
  logic [4:0]  e_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit stray;
    stray = 0;
    if (rst) begin
      ph = 0; c = 0; elapsed = 0; seen = 0;
      e_valid = 0; e_word = 0; e_comp = 0; e_res = 0; e_stray = 0; e_to = 0;
    end else begin
      e_valid = 0;
      if (ph == 2 && dr[c]) begin
        e_valid = 1; e_word = bs[32*c +: 32]; e_comp = 2'(c);
      end
      for (int i = 0; i < 3; i++)
        if (dr[i] && !(ph == 2 && i == c)) stray = 1;
      case (ph)
        0: if (start) begin
             ph = 1; c = 0; e_stray = 0; e_to = 0; e_res = 0; accepts++;
           end
        1: begin ph = 2; elapsed = 0; seen = 0; end
        2: if (seen) begin
             if (c == 2) ph = 3; else begin ph = 1; c++; end
           end else if (eob[c]) begin
             seen = 1; elapsed++;
             if (c == 2) e_res = rc[14:10];
           end else if (elapsed == TO - 1) begin
             e_to = 1; ph = 0;
           end else elapsed++;
        default: ph = 0;
      endcase
      if (stray) e_stray = 1;
    end
    e_ready = (ph == 0);
    e_en    = (ph == 1) ? 3'(1 << c) : 3'b000;
    e_done  = (ph == 3);
  endtask

  task automatic check_all();
    chk("ready", 32'(ready), 32'(e_ready));
    chk("enc_enable", 32'(enc_enable), 32'(e_en));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("out_word", out_word, e_word);
    chk("out_comp", 32'(out_comp), 32'(e_comp));
    chk("mcu_done", 32'(mcu_done), 32'(e_done));
    chk("residual_cnt", 32'(residual_cnt), 32'(e_res));
    chk("err_stray", 32'(err_stray), 32'(e_stray));
    chk("err_timeout", 32'(err_timeout), 32'(e_to));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic reach_wait(input int comp, input string name);
    int n;
    n = 0;
    while (!(ph == 2 && c == comp) && n < 40) begin
      eob = (ph == 2 && c < comp) ? 3'(1 << c) : 3'b000;
      cycle();
      n++;
    end
    eob = 3'b000;
    chk(name, 32'(ph == 2 && c == comp), 32'd1);
  endtask

  initial begin
    int t, t0, t1, t2, td, tr, tto, pulses, en_seen;
    bit to_ready;
    rst = 1; start = 0; dr = 0; eob = 0; bs = '0; rc = '0;
    cycle(); cycle();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_enable", 32'(enc_enable), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_errs", 32'({err_stray, err_timeout, mcu_done}), 32'd0);
    rst = 0;

    // Nominal MCU with fixed eob timing.
    t = cyc; t0 = -1; t1 = -1; t2 = -1; td = -1; tr = -1;
    rc = 15'(7 << 10);
    for (int k = 0; k < 20; k++) begin
      start = (k == 0);
      eob = (cyc == t + 5) ? 3'b001 : (cyc == t + 9) ? 3'b010 : (cyc == t + 14) ? 3'b100 : 3'b000;
      cycle();
      if (enc_enable[0]) t0 = cyc;
      if (enc_enable[1]) t1 = cyc;
      if (enc_enable[2]) t2 = cyc;
      if (mcu_done) td = cyc;
      if (ready && td >= 0 && tr < 0) tr = cyc;
    end
    start = 0; eob = 0;
    chk("nom_en_y", 32'(t0), 32'(t + 1));
    chk("nom_en_cb", 32'(t1), 32'(t + 7));
    chk("nom_en_cr", 32'(t2), 32'(t + 11));
    chk("nom_done", 32'(td), 32'(t + 16));
    chk("nom_ready", 32'(tr), 32'(t + 17));
    chk("nom_residual", 32'(residual_cnt), 32'd7);

    // Forwarding in WAIT_CB with a simultaneous stray Y word.
    start = 1; cycle(); start = 0;
    reach_wait(1, "reach_wait_cb");
    dr = 3'b011; bs = {32'h0, 32'hDEADBEEF, 32'h12345678};
    cycle();
    dr = 3'b000;
    chk("fwd_valid", 32'(out_valid), 32'd1);
    chk("fwd_word", out_word, 32'hDEADBEEF);
    chk("fwd_comp", 32'(out_comp), 32'd1);
    chk("fwd_stray", 32'(err_stray), 32'd1);
    for (int k = 0; k < 30; k++) begin
      eob = (ph == 2) ? 3'(1 << c) : 3'b000;
      cycle();
    end
    eob = 0;

    // Watchdog timeout while waiting on Y.
    t = cyc; tto = -1; en_seen = 0; to_ready = 0;
    for (int k = 0; k < 22; k++) begin
      start = (k == 0);
      cycle();
      if (enc_enable[1]) en_seen = 1;
      if (err_timeout && tto < 0) begin tto = cyc; to_ready = ready; end
    end
    chk("to_cycle", 32'(tto), 32'(t + 18));
    chk("to_ready", 32'(to_ready), 32'd1);
    chk("to_no_cb", 32'(en_seen), 32'd0);
    start = 1; cycle(); start = 0;
    chk("to_cleared", 32'(err_timeout), 32'd0);

    // Reset in WAIT_CB aborts the MCU.
    reach_wait(1, "reach_wait_cb2");
    rst = 1; cycle(); rst = 0;
    chk("mid_rst_ready", 32'(ready), 32'd1);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      pulses += int'(enc_enable != 3'b000) + int'(mcu_done);
    end
    chk("mid_rst_quiet", 32'(pulses), 32'd0);

    // Start held high: one sequence per IDLE acceptance.
    t = accepts; pulses = 0;
    start = 1;
    for (int k = 0; k < 200; k++) begin
      for (int i = 0; i < 3; i++) eob[i] = ($urandom_range(0, 3) == 0);
      cycle();
      if (enc_enable[0]) pulses++;
    end
    start = 0; eob = 0;
    chk("busy_start_count", 32'(pulses), 32'(accepts - t));

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < 3; i++) begin
        eob[i] = ($urandom_range(0, 5) == 0);
        dr[i]  = ($urandom_range(0, 4) == 0);
      end
      bs = {$urandom, $urandom, $urandom};
      rc = 15'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
